// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pooling over a row-major activation stream.
// Ports: clk, rst (async low), clear, in_valid/in_data -> out_valid/out_data/out_last, busy.
module maxpool2x2_stream #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NB = IMG_W / 2;
  localparam int AW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] pair_reg;
  logic [DW-1:0] rowbuf [NB];

  logic [AW-1:0] idx;
  logic [DW-1:0] hmax;
  logic [DW-1:0] rd;
  logic          col_last;
  logic          row_last;

  assign idx      = AW'(col >> 1);
  assign hmax     = (in_data > pair_reg) ? in_data : pair_reg;
  assign rd       = rowbuf[idx];
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign busy     = (col != '0) || (row != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      pair_reg  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < NB; i++) rowbuf[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (clear) begin
        col      <= '0;
        row      <= '0;
        pair_reg <= '0;
      end else if (in_valid) begin
        if (!col[0]) begin
          pair_reg <= in_data;
        end else if (!row[0]) begin
          // top half of the window: park the pair max
          rowbuf[idx] <= hmax;
        end else begin
          out_data  <= (rd > hmax) ? rd : hmax;
          out_valid <= 1'b1;
          out_last  <= row_last && col_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: 4x4 and 28x28 instances.
// Hand-computed windows for 4x4, direct window model for 28x28.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr4, v4, ov4, ol4, b4;
  logic [7:0] d4, od4;
  logic       clr28, v28, ov28, ol28, b28;
  logic [7:0] d28, od28;

  maxpool2x2_stream #(.IMG_W(4), .IMG_H(4), .DW(8)) dut4 (
    .clk(clk), .rst(rst), .clear(clr4),
    .in_valid(v4), .in_data(d4),
    .out_valid(ov4), .out_data(od4),
    .out_last(ol4), .busy(b4)
  );

  maxpool2x2_stream #(.IMG_W(28), .IMG_H(28), .DW(8)) dut28 (
    .clk(clk), .rst(rst), .clear(clr28),
    .in_valid(v28), .in_data(d28),
    .out_valid(ov28), .out_data(od28),
    .out_last(ol28), .busy(b28)
  );

  int checks = 0;
  int failures = 0;
  int pulses28 = 0;
  logic [7:0] hold4 = 8'd0;
  logic [7:0] hold28 = 8'd0;
  logic [7:0] pix4 [16];
  logic [7:0] exp4 [4];
  logic [7:0] pix28 [784];

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic px4(input logic [7:0] d, input bit ev, input logic [7:0] ed,
                     input bit el, input bit eb);
    v4 = 1'b1;
    d4 = d;
    @(posedge clk);
    #1;
    v4 = 1'b0;
    if (ev) hold4 = ed;
    chk("p4_valid", {31'd0, ov4}, {31'd0, ev});
    chk("p4_data", {24'd0, od4}, {24'd0, hold4});
    chk("p4_last", {31'd0, ol4}, {31'd0, ev & el});
    chk("p4_busy", {31'd0, b4}, {31'd0, eb});
  endtask

  task automatic idle4(input bit eb);
    d4 = 8'hEE;
    @(posedge clk);
    #1;
    chk("i4_valid", {31'd0, ov4}, 32'd0);
    chk("i4_data", {24'd0, od4}, {24'd0, hold4});
    chk("i4_busy", {31'd0, b4}, {31'd0, eb});
  endtask

  task automatic frame4(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      bit ev;
      int w;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      w  = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : 3;
      px4(pix4[i], ev, exp4[w], i == 15, i != 15);
      if (gaps) idle4(i != 15);
    end
  endtask

  task automatic px28(input logic [7:0] d, input bit ev, input logic [7:0] ed, input bit el);
    v28 = 1'b1;
    d28 = d;
    @(posedge clk);
    #1;
    v28 = 1'b0;
    if (ev) hold28 = ed;
    if (ov28) pulses28++;
    chk("p28_valid", {31'd0, ov28}, {31'd0, ev});
    chk("p28_data", {24'd0, od28}, {24'd0, hold28});
    chk("p28_last", {31'd0, ol28}, {31'd0, ev & el});
  endtask

  task automatic idle28();
    d28 = 8'($urandom_range(255));
    @(posedge clk);
    #1;
    if (ov28) pulses28++;
    chk("i28_valid", {31'd0, ov28}, 32'd0);
    chk("i28_data", {24'd0, od28}, {24'd0, hold28});
  endtask

  initial begin
    rst = 1'b0;
    clr4 = 1'b0; v4 = 1'b1; d4 = 8'd77;
    clr28 = 1'b0; v28 = 1'b0; d28 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ov4}, 32'd0);
    chk("rst_data", {24'd0, od4}, 32'd0);
    chk("rst_last", {31'd0, ol4}, 32'd0);
    chk("rst_busy", {31'd0, b4}, 32'd0);
    chk("rst_busy28", {31'd0, b28}, 32'd0);
    v4 = 1'b0;
    rst = 1'b1;

    // ascending frame, back-to-back
    for (int i = 0; i < 16; i++) pix4[i] = 8'(i);
    exp4[0] = 8'd5; exp4[1] = 8'd7; exp4[2] = 8'd13; exp4[3] = 8'd15;
    frame4(1'b0);

    // same frame with gaps
    frame4(1'b1);

    // descending frame then flat frame, no idle between
    for (int i = 0; i < 16; i++) pix4[i] = 8'(255 - i);
    exp4[0] = 8'd255; exp4[1] = 8'd253; exp4[2] = 8'd247; exp4[3] = 8'd245;
    frame4(1'b0);
    for (int i = 0; i < 16; i++) pix4[i] = 8'h80;
    for (int i = 0; i < 4; i++) exp4[i] = 8'h80;
    frame4(1'b0);

    // abort by clear after 6 pixels
    for (int i = 0; i < 6; i++) px4(8'(200 + i), i == 5, 8'd205, 1'b0, 1'b1);
    clr4 = 1'b1; v4 = 1'b1; d4 = 8'd250;
    @(posedge clk);
    #1;
    clr4 = 1'b0; v4 = 1'b0;
    chk("clr_busy", {31'd0, b4}, 32'd0);
    chk("clr_valid", {31'd0, ov4}, 32'd0);
    chk("clr_data", {24'd0, od4}, {24'd0, hold4});
    for (int i = 0; i < 16; i++) pix4[i] = 8'(i);
    exp4[0] = 8'd5; exp4[1] = 8'd7; exp4[2] = 8'd13; exp4[3] = 8'd15;
    frame4(1'b0);

    // async reset mid-frame at row 1, col 1
    for (int i = 0; i < 5; i++) px4(8'(i), 1'b0, 8'd0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    hold4 = 8'd0;
    chk("arst_valid", {31'd0, ov4}, 32'd0);
    chk("arst_data", {24'd0, od4}, 32'd0);
    chk("arst_busy", {31'd0, b4}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    frame4(1'b0);

    // 28x28 random frame with random gaps
    for (int k = 0; k < 784; k++) pix28[k] = 8'($urandom_range(255));
    for (int k = 0; k < 784; k++) begin
      int r;
      int c;
      bit ev;
      logic [7:0] e;
      r = k / 28;
      c = k % 28;
      ev = (r % 2 == 1) && (c % 2 == 1);
      e = 8'd0;
      if (ev) e = mx(mx(pix28[k], pix28[k-1]), mx(pix28[k-28], pix28[k-29]));
      if ($urandom_range(2) == 0) idle28();
      px28(pix28[k], ev, e, k == 783);
    end
    idle28();
    chk("p28_count", pulses28, 32'd196);
    chk("p28_busy_end", {31'd0, b28}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
